// File: rtl/ddr3_wb_arbiter.sv
// ddr3_wb_arbiter: two-requester round-robin arbiter in front of the
// single pipelined Wishbone slave port of ddr3_top.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_wbN_*  (N=0,1)      requester N: cyc/stb/we/addr/data/sel/aux
//   o_wbN_stall/ack       handshake back to requester N
//   o_wbN_data/aux        read data / aux returned to requester N
//   o_wb_*                request bus to ddr3_top
//   i_wb_stall/ack/data/aux  response from ddr3_top
//
// One requester owns the bus at a time. The owner's outstanding requests
// are counted so ownership only moves once its pipeline has drained
// (or the owner dropped cyc, which makes the slave cancel everything).

module ddr3_wb_arbiter #(
  parameter int ADDR_BITS       = 24,
  parameter int DATA_BITS       = 128,
  parameter int SEL_BITS        = 16,
  parameter int AUX_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  // requester 0
  input  logic                 i_wb0_cyc,
  input  logic                 i_wb0_stb,
  input  logic                 i_wb0_we,
  input  logic [ADDR_BITS-1:0] i_wb0_addr,
  input  logic [DATA_BITS-1:0] i_wb0_data,
  input  logic [SEL_BITS-1:0]  i_wb0_sel,
  input  logic [AUX_WIDTH-1:0] i_wb0_aux,
  output logic                 o_wb0_stall,
  output logic                 o_wb0_ack,
  output logic [DATA_BITS-1:0] o_wb0_data,
  output logic [AUX_WIDTH-1:0] o_wb0_aux,
  // requester 1
  input  logic                 i_wb1_cyc,
  input  logic                 i_wb1_stb,
  input  logic                 i_wb1_we,
  input  logic [ADDR_BITS-1:0] i_wb1_addr,
  input  logic [DATA_BITS-1:0] i_wb1_data,
  input  logic [SEL_BITS-1:0]  i_wb1_sel,
  input  logic [AUX_WIDTH-1:0] i_wb1_aux,
  output logic                 o_wb1_stall,
  output logic                 o_wb1_ack,
  output logic [DATA_BITS-1:0] o_wb1_data,
  output logic [AUX_WIDTH-1:0] o_wb1_aux,
  // shared slave port
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_BITS-1:0] o_wb_addr,
  output logic [DATA_BITS-1:0] o_wb_data,
  output logic [SEL_BITS-1:0]  o_wb_sel,
  output logic [AUX_WIDTH-1:0] o_wb_aux,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic [DATA_BITS-1:0] i_wb_data,
  input  logic [AUX_WIDTH-1:0] i_wb_aux
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT =
    CW'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] count_q, count_d;

  // selected-requester view
  logic own;
  logic sel_cyc;
  logic sel_stb;
  logic oth_cyc;
  logic full;
  logic accept;
  logic ack_dec;
  logic own_stall;

  always_comb begin
    own     = (state_q == OWN);
    sel_cyc = owner_q ? i_wb1_cyc : i_wb0_cyc;
    sel_stb = owner_q ? i_wb1_stb : i_wb0_stb;
    oth_cyc = owner_q ? i_wb0_cyc : i_wb1_cyc;
    full    = (count_q == MAX_CNT);
  end

  // request path: zero-latency mux from the owner
  always_comb begin
    o_wb_cyc  = own && sel_cyc;
    o_wb_stb  = own && sel_cyc && sel_stb
                && (count_q < MAX_CNT);
    o_wb_we   = owner_q ? i_wb1_we   : i_wb0_we;
    o_wb_addr = owner_q ? i_wb1_addr : i_wb0_addr;
    o_wb_data = owner_q ? i_wb1_data : i_wb0_data;
    o_wb_sel  = owner_q ? i_wb1_sel  : i_wb0_sel;
    o_wb_aux  = owner_q ? i_wb1_aux  : i_wb0_aux;
  end

  // stall depends only on slave stall and the registered count,
  // never on the requester's own stb
  always_comb begin
    own_stall   = i_wb_stall || full;
    o_wb0_stall = 1'b1;
    o_wb1_stall = 1'b1;
    o_wb0_ack   = 1'b0;
    o_wb1_ack   = 1'b0;
    if (own) begin
      if (owner_q) begin
        o_wb1_stall = own_stall;
        o_wb1_ack   = i_wb_ack;
      end else begin
        o_wb0_stall = own_stall;
        o_wb0_ack   = i_wb_ack;
      end
    end
  end

  // read data and aux are broadcast; only acks are routed
  always_comb begin
    o_wb0_data = i_wb_data;
    o_wb1_data = i_wb_data;
    o_wb0_aux  = i_wb_aux;
    o_wb1_aux  = i_wb_aux;
  end

  always_comb begin
    accept  = o_wb_stb && !i_wb_stall;
    // spurious ack at zero is forwarded but must not underflow
    ack_dec = i_wb_ack && (count_q != '0);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (i_wb0_cyc && i_wb1_cyc) begin
          state_d = OWN;
          owner_d = ~last_owner_q;
        end else if (i_wb0_cyc || i_wb1_cyc) begin
          state_d = OWN;
          owner_d = i_wb1_cyc;
        end
      end
      OWN: begin
        count_d = count_q
                  + CW'(accept)
                  - CW'(ack_dec);
        if (!sel_cyc) begin
          // slave cancels pending work when cyc drops
          state_d      = IDLE;
          last_owner_d = owner_q;
          count_d      = '0;
        end else if (count_q == '0 && !sel_stb
                     && oth_cyc) begin
          // drained and between bursts: let the other side in
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// tb_ddr3_wb_arbiter: directed checks of ddr3_wb_arbiter followed by a
// randomised phase against a scoreboard-driven pipelined slave.

module tb_ddr3_wb_arbiter;

  logic         clk;
  logic         rst;
  logic         c0, s0, w0, c1, s1, w1;
  logic [23:0]  a0, a1;
  logic [127:0] d0, d1;
  logic [15:0]  sel0, sel1;
  logic [3:0]   x0, x1;
  logic         st0, ak0, st1, ak1;
  logic [127:0] od0, od1;
  logic [3:0]   ox0, ox1;
  logic         m_cyc, m_stb, m_we;
  logic [23:0]  m_addr;
  logic [127:0] m_data;
  logic [15:0]  m_sel;
  logic [3:0]   m_aux;
  logic         sl_stall, sl_ack;
  logic [127:0] sl_data;
  logic [3:0]   sl_aux;

  int n_chk  = 0;
  int n_fail = 0;

  ddr3_wb_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb0_cyc  (c0),
    .i_wb0_stb  (s0),
    .i_wb0_we   (w0),
    .i_wb0_addr (a0),
    .i_wb0_data (d0),
    .i_wb0_sel  (sel0),
    .i_wb0_aux  (x0),
    .o_wb0_stall(st0),
    .o_wb0_ack  (ak0),
    .o_wb0_data (od0),
    .o_wb0_aux  (ox0),
    .i_wb1_cyc  (c1),
    .i_wb1_stb  (s1),
    .i_wb1_we   (w1),
    .i_wb1_addr (a1),
    .i_wb1_data (d1),
    .i_wb1_sel  (sel1),
    .i_wb1_aux  (x1),
    .o_wb1_stall(st1),
    .o_wb1_ack  (ak1),
    .o_wb1_data (od1),
    .o_wb1_aux  (ox1),
    .o_wb_cyc   (m_cyc),
    .o_wb_stb   (m_stb),
    .o_wb_we    (m_we),
    .o_wb_addr  (m_addr),
    .o_wb_data  (m_data),
    .o_wb_sel   (m_sel),
    .o_wb_aux   (m_aux),
    .i_wb_stall (sl_stall),
    .i_wb_ack   (sl_ack),
    .i_wb_data  (sl_data),
    .i_wb_aux   (sl_aux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    c0 = 0; s0 = 0; w0 = 0; a0 = '0; d0 = '0;
    sel0 = '0; x0 = '0;
    c1 = 0; s1 = 0; w1 = 0; a1 = '0; d1 = '0;
    sel1 = '0; x1 = '0;
    sl_stall = 0; sl_ack = 0;
    sl_data = '0; sl_aux = '0;
  endtask

  task automatic rst_pulse();
    rst = 1;
    tick();
    rst = 0;
  endtask

  int    qdue[$];
  logic [3:0] qaux[$];
  int    last_due;
  int    due;

  initial begin
    clr_inputs();
    rst = 1;
    // ---------------- reset
    tick();
    tick();
    chk("rst_cyc", m_cyc, 0);
    chk("rst_stb", m_stb, 0);
    chk("rst_st0", st0, 1);
    chk("rst_st1", st1, 1);
    chk("rst_ak0", ak0, 0);
    chk("rst_cnt", dut.count_q, 0);
    rst = 0;
    tick();

    // ---------------- single requester write
    c0 = 1; s0 = 1; w0 = 1;
    a0 = 24'h9E; d0 = 128'h61;
    sel0 = 16'hFFFF; x0 = 4'h3;
    settle();
    chk("s_idle_cyc", m_cyc, 0);
    chk("s_idle_st0", st0, 1);
    tick();
    chk("s_cyc", m_cyc, 1);
    chk("s_stb", m_stb, 1);
    chk("s_we", m_we, 1);
    chk("s_addr", m_addr, 24'h9E);
    chk("s_data", m_data, 128'h61);
    chk("s_sel", m_sel, 16'hFFFF);
    chk("s_aux", m_aux, 4'h3);
    chk("s_st0", st0, 0);
    chk("s_st1", st1, 1);
    tick();
    s0 = 0;
    settle();
    chk("s_cnt1", dut.count_q, 1);
    chk("s_noack", ak0, 0);
    tick();
    tick();
    sl_ack = 1;
    sl_data = 128'hDEAD_BEEF;
    sl_aux = 4'h5;
    settle();
    chk("s_ak0", ak0, 1);
    chk("s_ak1", ak1, 0);
    chk("s_od0", od0, 128'hDEAD_BEEF);
    chk("s_od1", od1, 128'hDEAD_BEEF);
    chk("s_ox0", ox0, 4'h5);
    tick();
    sl_ack = 0;
    c0 = 0;
    settle();
    chk("s_cnt0", dut.count_q, 0);
    chk("s_ak0_once", ak0, 0);
    chk("s_rel_cyc", m_cyc, 0);
    tick();
    chk("s_idle_st0b", st0, 1);
    chk("s_idle_cycb", m_cyc, 0);

    // ---------------- contention / round robin
    clr_inputs();
    rst_pulse();
    c0 = 1; c1 = 1;
    a0 = 24'h111; a1 = 24'h222;
    settle();
    chk("c_idle_st0", st0, 1);
    chk("c_idle_st1", st1, 1);
    chk("c_idle_cyc", m_cyc, 0);
    tick();
    chk("c_g0_st0", st0, 0);
    chk("c_g0_st1", st1, 1);
    chk("c_g0_addr", m_addr, 24'h111);
    s0 = 1;
    settle();
    chk("c_g0_stb", m_stb, 1);
    tick();
    s0 = 0;
    sl_ack = 1;
    settle();
    chk("c_g0_ak0", ak0, 1);
    chk("c_g0_ak1", ak1, 0);
    tick();
    sl_ack = 0;
    settle();
    chk("c_g0_hold", m_cyc, 1);
    tick();
    chk("c_ho_st0", st0, 1);
    chk("c_ho_st1", st1, 1);
    chk("c_ho_cyc", m_cyc, 0);
    tick();
    chk("c_g1_st1", st1, 0);
    chk("c_g1_st0", st0, 1);
    chk("c_g1_addr", m_addr, 24'h222);
    c1 = 0;
    settle();
    chk("c_g1_drop", m_cyc, 0);
    tick();
    c1 = 1;
    settle();
    chk("c_tie_idle", m_cyc, 0);
    tick();
    chk("c_tie_st0", st0, 0);
    chk("c_tie_st1", st1, 1);
    chk("c_tie_addr", m_addr, 24'h111);
    c0 = 0; c1 = 0;
    tick();

    // ---------------- backpressure at MAX_OUTSTANDING
    clr_inputs();
    rst_pulse();
    c0 = 1; s0 = 1;
    tick();
    repeat (16) tick();
    chk("b_cnt16", dut.count_q, 16);
    chk("b_stb0", m_stb, 0);
    chk("b_st0", st0, 1);
    sl_ack = 1;
    settle();
    chk("b_ak0", ak0, 1);
    chk("b_stb0b", m_stb, 0);
    tick();
    sl_ack = 0;
    settle();
    chk("b_cnt15", dut.count_q, 15);
    chk("b_stb1", m_stb, 1);
    chk("b_st0_lo", st0, 0);
    tick();
    chk("b_cnt16b", dut.count_q, 16);
    chk("b_stb0c", m_stb, 0);
    sl_ack = 1;
    tick();
    settle();
    chk("b_cnt15b", dut.count_q, 15);
    chk("b_stb1b", m_stb, 1);
    tick();
    sl_ack = 0;
    settle();
    chk("b_both", dut.count_q, 15);
    tick();
    chk("b_cnt16c", dut.count_q, 16);
    c0 = 0;
    settle();
    chk("b_drop", m_cyc, 0);
    tick();
    chk("b_clr", dut.count_q, 0);
    s0 = 0;

    // ---------------- spurious ack and abort
    clr_inputs();
    rst_pulse();
    c1 = 1;
    tick();
    sl_ack = 1;
    settle();
    chk("a_spur_ak1", ak1, 1);
    chk("a_spur_ak0", ak0, 0);
    tick();
    sl_ack = 0;
    s1 = 1;
    settle();
    chk("a_spur_cnt", dut.count_q, 0);
    chk("a_stb", m_stb, 1);
    repeat (3) tick();
    chk("a_cnt3", dut.count_q, 3);
    s1 = 0; c1 = 0;
    settle();
    chk("a_cyc", m_cyc, 0);
    chk("a_stb0", m_stb, 0);
    tick();
    sl_ack = 1;
    settle();
    chk("a_late_ak1", ak1, 0);
    chk("a_late_ak0", ak0, 0);
    chk("a_cnt0", dut.count_q, 0);
    tick();
    settle();
    chk("a_late2_ak1", ak1, 0);
    sl_ack = 0;

    // ---------------- random traffic vs scoreboard
    clr_inputs();
    rst_pulse();
    x0 = 4'h1;
    x1 = 4'h2;
    last_due = 0;
    for (int n = 0; n < 3000; n++) begin
      sl_ack = (qdue.size() > 0) && (qdue[0] <= n);
      sl_aux = sl_ack ? qaux[0] : 4'h0;
      sl_data = {4{$urandom}};
      if ($urandom_range(0, 19) == 0) c0 = ~c0;
      if ($urandom_range(0, 19) == 0) c1 = ~c1;
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      a0 = 24'($urandom);
      a1 = 24'($urandom);
      sl_stall = ($urandom_range(0, 3) == 0);
      settle();
      chk("r_ak0", ak0, sl_ack && sl_aux == 4'h1);
      chk("r_ak1", ak1, sl_ack && sl_aux == 4'h2);
      chk("r_cnt", dut.count_q, qdue.size());
      chk("r_max", dut.count_q <= 16, 1);
      if (sl_ack) begin
        void'(qdue.pop_front());
        void'(qaux.pop_front());
      end
      if (m_stb && !sl_stall) begin
        due = n + $urandom_range(1, 8);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        qdue.push_back(due);
        qaux.push_back(m_aux);
      end
      if (!m_cyc) begin
        qdue.delete();
        qaux.delete();
        last_due = n;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
